// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; sign correction is applied in FIX.
module mult_div_unit #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_FUNCT = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_FUNCT-1:0] i_funct,
  input  logic [NB_DATA-1:0]  i_operand_A,
  input  logic [NB_DATA-1:0]  i_operand_B,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_div_by_zero,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo
);

  localparam int unsigned NB_IDX = $clog2(NB_DATA);
  localparam int unsigned NB_CNT = NB_IDX + 1;

  localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
  localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
  localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
  localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);
  localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
  localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t                 state_q, state_d;
  logic                   is_div_q, is_div_d;
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic [NB_DATA-1:0]     a_q, a_d;
  logic [NB_DATA-1:0]     b_q, b_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [NB_DATA-1:0]     hi_q, hi_d;
  logic [NB_DATA-1:0]     lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   dbz_q, dbz_d;

  logic [NB_IDX-1:0]      bit_idx;
  logic [NB_IDX-1:0]      div_idx;
  logic [NB_DATA:0]       mul_sum;
  logic [2*NB_DATA-1:0]   acc_mul;
  logic [NB_DATA:0]       rem_sh;
  logic [NB_DATA+1:0]     rem_diff;
  logic [2*NB_DATA-1:0]   acc_div;
  logic                   signed_op;

  always_comb begin
    // Multiply: accumulator shifts right, consuming multiplier bits LSB first.
    bit_idx = cnt_q[NB_IDX-1:0];
    mul_sum = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (b_q[bit_idx] ? {1'b0, a_q} : '0);
    acc_mul = {mul_sum, acc_q[NB_DATA-1:1]};

    // Divide: remainder in the upper half, quotient shifts into the lower half.
    div_idx  = NB_IDX'(NB_DATA - 1) - bit_idx;
    rem_sh   = {acc_q[2*NB_DATA-1:NB_DATA], a_q[div_idx]};
    rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
    if (!rem_diff[NB_DATA+1])
      acc_div = {rem_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
    else
      acc_div = {rem_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    signed_op = ~i_funct[0];

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_funct == F_MULT || i_funct == F_MULTU ||
              i_funct == F_DIV  || i_funct == F_DIVU) begin
            is_div_d = i_funct[1];
            sign_a_d = signed_op & i_operand_A[NB_DATA-1];
            sign_b_d = signed_op & i_operand_B[NB_DATA-1];
            a_d      = sign_a_d ? -i_operand_A : i_operand_A;
            b_d      = sign_b_d ? -i_operand_B : i_operand_B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_RUN;
          end else if (i_funct == F_MTHI) begin
            hi_d = i_operand_A;
          end else if (i_funct == F_MTLO) begin
            lo_d = i_operand_A;
          end
        end
      end
      ST_RUN: begin
        acc_d = is_div_q ? acc_div : acc_mul;
        if (cnt_q == NB_CNT'(NB_DATA - 1)) state_d = ST_FIX;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        end else if (b_q == '0) begin
          // The dividend is rebuilt from its magnitude and sign flag.
          hi_d  = sign_a_q ? -a_q : a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
          hi_d = sign_a_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_div_by_zero = dbz_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed and random ops checked against a
// plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_funct = '0;
  logic [31:0] i_operand_A = '0;
  logic [31:0] i_operand_B = '0;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.NB_DATA(32), .NB_FUNCT(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct(i_funct),
    .i_operand_A(i_operand_A), .i_operand_B(i_operand_B),
    .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (f)
      F_MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      F_MULTU: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFFFFFF; ed = 1'b1;
        end else if (f == F_DIV) begin
          q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0];
        end else begin
          up = ua / ub; eh = 32'(ua % ub); el = up[31:0];
        end
      end
    endcase
  endtask

  // inj > 0: re-assert start with changed operands at that busy cycle.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int inj);
    logic [31:0] eh, el;
    logic ed;
    int bc;
    model(f, a, b, eh, el, ed);
    i_start = 1'b1; i_funct = f; i_operand_A = a; i_operand_B = b;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("done_low_at_start", {63'b0, o_done}, 64'd0);
    bc = 0;
    while (o_busy && bc < 40) begin
      bc++;
      if (bc == inj) begin
        i_start = 1'b1; i_funct = F_MULT;
        i_operand_A = $urandom; i_operand_B = $urandom;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    chk("busy_cycles", 64'(bc), 64'd33);
    chk("done_pulse", {63'b0, o_done}, 64'd1);
    chk("div_by_zero", {63'b0, o_div_by_zero}, {63'b0, ed});
    chk("hi", {32'b0, o_hi}, {32'b0, eh});
    chk("lo", {32'b0, o_lo}, {32'b0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic do_move(input logic [5:0] f, input logic [31:0] a);
    i_start = 1'b1; i_funct = f; i_operand_A = a; i_operand_B = $urandom;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    if (f == F_MTHI) m_hi = a;
    if (f == F_MTLO) m_lo = a;
    chk("move_busy", {63'b0, o_busy}, 64'd0);
    chk("move_done", {63'b0, o_done}, 64'd0);
    chk("move_hi", {32'b0, o_hi}, {32'b0, m_hi});
    chk("move_lo", {32'b0, o_lo}, {32'b0, m_lo});
  endtask

  initial begin
    logic [5:0] ftab [6];
    logic [5:0] f;
    logic [31:0] a, b;
    int dn;
    ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV;
    ftab[3] = F_DIVU; ftab[4] = F_MTHI;  ftab[5] = F_MTLO;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", {63'b0, o_busy}, 64'd0);
    chk("rst_done", {63'b0, o_done}, 64'd0);
    chk("rst_dbz", {63'b0, o_div_by_zero}, 64'd0);
    chk("rst_hi", {32'b0, o_hi}, 64'd0);
    chk("rst_lo", {32'b0, o_lo}, 64'd0);
    i_rst = 1'b0;

    do_op(F_MULT,  32'hFFFFFFFD, 32'd7, 0);
    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(F_DIV,   32'hFFFFFFF9, 32'd2, 0);
    do_op(F_DIVU,  32'd100, 32'd7, 0);
    do_op(F_DIVU,  32'd100, 32'd0, 0);
    do_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
    do_op(F_DIV,   32'hFFFFFF00, 32'd0, 0);
    do_op(F_MULT,  32'h0001E240, 32'hFFFFFC18, 5);
    do_move(F_MTHI, 32'h12345678);
    do_move(F_MTLO, 32'h9ABCDEF0);
    do_move(6'b100000, 32'hDEADBEEF);

    for (int n = 0; n < 24; n++) begin
      f = ftab[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if (f == F_MTHI || f == F_MTLO) do_move(f, a);
      else                            do_op(f, a, b, 0);
    end

    // Reset in the middle of an operation aborts it with no done pulse.
    i_start = 1'b1; i_funct = F_DIV; i_operand_A = $urandom; i_operand_B = $urandom;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst_busy", {63'b0, o_busy}, 64'd0);
    chk("midrst_done", {63'b0, o_done}, 64'd0);
    chk("midrst_hi", {32'b0, o_hi}, 64'd0);
    chk("midrst_lo", {32'b0, o_lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) dn++;
    end
    chk("midrst_quiet", 64'(dn), 64'd0);
    do_op(F_MULTU, 32'd123456, 32'd654321, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
